// File: rtl/uart_pkg.sv
// Shared UART definitions used by uart_tx and uart_rx.
//   UART_DATA_BITS    : payload bits per frame (8N1)
//   UART_CLKS_PER_BIT : default bit period minus one, in clock cycles
//   uart_rx_state_t   : receiver FSM state encoding
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 120;

    typedef enum logic [2:0] {
        ST_WAIT_HIGH = 3'd0,
        ST_IDLE      = 3'd1,
        ST_START     = 3'd2,
        ST_DATA      = 3'd3,
        ST_STOP      = 3'd4
    } uart_rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input.
//   I_clk     : destination clock
//   I_reset   : synchronous reset, active-high; both flops load RESET_VAL
//   d         : asynchronous input
//   q         : synchronised output, two cycles behind d
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic I_clk,
    input  logic I_reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, fixed baud. One bit lasts CLKS_PER_BIT+1
// clocks; each bit is sampled at mid-bit and the byte is presented through a
// valid/ack register.
//   I_clk, I_reset : clock, synchronous active-high reset
//   I_rx           : asynchronous serial line, idle high
//   I_ack          : consumer took O_data (ignored while O_valid=0)
//   O_data         : last received byte, stable while O_valid=1
//   O_valid        : O_data holds an unconsumed byte
//   O_busy         : a frame is in progress
//   O_frame_err    : one-cycle pulse, stop bit sampled low
//   O_overrun      : sticky, a byte was overwritten before being acked
//
// Handshake: a byte is transferred in every cycle where O_valid=1 and
// I_ack=1; O_valid drops the next cycle unless a new byte lands in that same
// cycle, in which case O_valid stays high with the new byte.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                      I_clk,
    input  logic                      I_reset,
    input  logic                      I_rx,
    input  logic                      I_ack,
    output logic [UART_DATA_BITS-1:0] O_data,
    output logic                      O_valid,
    output logic                      O_busy,
    output logic                      O_frame_err,
    output logic                      O_overrun
);

    localparam int         HALF_BIT = (CLKS_PER_BIT + 1) / 2;
    localparam logic [7:0] HALF_HIT = 8'(HALF_BIT - 1);
    localparam logic [7:0] BIT_HIT  = 8'(CLKS_PER_BIT);

    uart_rx_state_t            state, state_nxt;
    logic [7:0]                cnt;
    logic [2:0]                bit_idx;
    logic                      bit_done;
    logic [UART_DATA_BITS-1:0] shift;
    logic [1:0]                sync_fill;
    logic                      rx_s;
    logic                      cnt_hit;
    logic                      shift_en;
    logic                      deliver;
    logic                      frame_bad;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .I_clk   (I_clk),
        .I_reset (I_reset),
        .d       (I_rx),
        .q       (rx_s)
    );

    // The synchroniser flops hold their reset value for two cycles after
    // reset, so a low line would look high for those cycles. WAIT_HIGH ignores
    // rx_s until the flops carry the real line, which keeps a frame cut by
    // reset from being mistaken for a fresh start bit.
    always_ff @(posedge I_clk) begin
        if (I_reset) sync_fill <= 2'b00;
        else         sync_fill <= {sync_fill[0], 1'b1};
    end

    // The start phase counts to the half-bit point; later phases count whole bits.
    assign cnt_hit  = (state == ST_START) ? (cnt == HALF_HIT) : (cnt == BIT_HIT);
    assign bit_done = (bit_idx == 3'(UART_DATA_BITS - 1));

    // FSM state register
    always_ff @(posedge I_clk) begin
        if (I_reset) state <= ST_WAIT_HIGH;
        else         state <= state_nxt;
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_WAIT_HIGH: if (sync_fill[1] && rx_s) state_nxt = ST_IDLE;
            ST_IDLE:      if (!rx_s)                state_nxt = ST_START;
            ST_START:     if (cnt_hit)              state_nxt = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:      if (cnt_hit && bit_done)  state_nxt = ST_STOP;
            ST_STOP:      if (cnt_hit)              state_nxt = rx_s ? ST_IDLE : ST_WAIT_HIGH;
            default:                                state_nxt = ST_WAIT_HIGH;
        endcase
    end

    // FSM outputs
    always_comb begin
        O_busy    = (state != ST_IDLE) && (state != ST_WAIT_HIGH);
        shift_en  = (state == ST_DATA) && cnt_hit;
        deliver   = (state == ST_STOP) && cnt_hit && rx_s;
        frame_bad = (state == ST_STOP) && cnt_hit && !rx_s;
    end

    // Bit timing counters and shift register
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            if (!O_busy || cnt_hit) cnt <= '0;
            else                    cnt <= cnt + 8'd1;

            if (state != ST_DATA)   bit_idx <= '0;
            else if (shift_en)      bit_idx <= bit_done ? 3'd0 : bit_idx + 3'd1;

            // LSB arrives first, so shifting right leaves bit 0 in shift[0].
            if (shift_en) shift <= {rx_s, shift[UART_DATA_BITS-1:1]};
        end
    end

    // Consumer-side registers
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            O_data      <= '0;
            O_valid     <= 1'b0;
            O_frame_err <= 1'b0;
            O_overrun   <= 1'b0;
        end else begin
            O_frame_err <= frame_bad;

            if (deliver) begin
                O_data  <= shift;
                O_valid <= 1'b1;
            end else if (O_valid && I_ack) begin
                O_valid <= 1'b0;
            end

            // Setting takes priority over the ack clear.
            if (deliver && O_valid && !I_ack) O_overrun <= 1'b1;
            else if (O_valid && I_ack)        O_overrun <= 1'b0;
        end
    end

endmodule
